// File: rtl/sw_pkg.sv
// Shared encodings for the stopwatch control unit: FSM state codes and
// button bit positions within PSW.
package sw_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STOP = 2'b10;
  localparam logic [1:0] ST_LAP  = 2'b11;

  localparam int BTN_START = 3;
  localparam int BTN_STOP  = 2;
  localparam int BTN_CLR   = 1;
  localparam int BTN_LAP   = 0;

  // The count advances in both RUN and LAP; LAP only freezes the display.
  function automatic logic is_active(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One push button: 2-FF synchroniser, stable-level debounce counter and a
// single-cycle pulse on each accepted press (debounced 0->1).
module sw_debounce #(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          level_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive mismatch cycles; any agreeing cycle restarts from zero.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/sw_ctrl.sv
// Stopwatch control unit: debounced buttons drive the IDLE/RUN/STOP/LAP FSM,
// which gates the 100 Hz prescaler and emits clear, lap and display controls.
module sw_ctrl
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int TICK_DIV     = 10,
  parameter int STOP_ON_WRAP = 1
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] PSW,
  input  logic       wrap_in,
  output logic       tick_en,
  output logic       cnt_clr,
  output logic       lap_latch,
  output logic       disp_lap,
  output logic [1:0] state,
  output logic [7:0] LED
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic WRAP_STOPS = (STOP_ON_WRAP != 0);

  logic [3:0]    press;
  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          cnt_clr_q;
  logic          cnt_clr_d;
  logic          lap_latch_q;
  logic          lap_latch_d;
  logic          disp_lap_q;
  logic          sticky_q;
  logic          sticky_d;
  logic [7:0]    led_q;
  logic          wrap_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    sw_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .clk_i  (CLK),
      .rst_ni (RSTn),
      .btn_i  (PSW[gi]),
      .press_o(press[gi])
    );
  end

  assign tick_en  = is_active(state_q) && (presc_q == PW'(TICK_DIV - 1));
  assign wrap_hit = wrap_in && tick_en;

  // Each branch tests presses in clear > stop > lap > start order, skipping
  // presses that mean nothing in the current state; wrap pre-empts buttons.
  always_comb begin
    state_d     = state_q;
    cnt_clr_d   = 1'b0;
    lap_latch_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press[BTN_CLR]) begin
          cnt_clr_d = 1'b1;
        end else if (press[BTN_START]) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wrap_hit && WRAP_STOPS) begin
          state_d = ST_STOP;
        end else if (press[BTN_STOP]) begin
          state_d = ST_STOP;
        end else if (press[BTN_LAP]) begin
          state_d     = ST_LAP;
          lap_latch_d = 1'b1;
        end
      end
      ST_LAP: begin
        if (wrap_hit && WRAP_STOPS) begin
          state_d = ST_STOP;
        end else if (press[BTN_STOP]) begin
          state_d = ST_STOP;
        end else if (press[BTN_LAP]) begin
          state_d = ST_RUN;
        end
      end
      ST_STOP: begin
        if (press[BTN_CLR]) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end else if (press[BTN_START]) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // STOP holds the prescaler so a resume keeps the sub-tick phase.
  always_comb begin
    presc_d = presc_q;
    if (is_active(state_q)) begin
      presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + 1'b1;
    end else if (state_q == ST_IDLE) begin
      presc_d = '0;
    end
  end

  assign sticky_d = cnt_clr_d ? 1'b0 : (sticky_q | wrap_hit);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      cnt_clr_q   <= 1'b0;
      lap_latch_q <= 1'b0;
      disp_lap_q  <= 1'b0;
      sticky_q    <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      cnt_clr_q   <= cnt_clr_d;
      lap_latch_q <= lap_latch_d;
      disp_lap_q  <= (state_d == ST_LAP);
      sticky_q    <= sticky_d;
      led_q       <= {4'b0000, sticky_d, (state_d == ST_STOP),
                      (state_d == ST_LAP), is_active(state_d)};
    end
  end

  assign state     = state_q;
  assign cnt_clr   = cnt_clr_q;
  assign lap_latch = lap_latch_q;
  assign disp_lap  = disp_lap_q;
  assign LED       = led_q;

endmodule

// File: tb/tb_sw_ctrl.sv
// Bench for sw_ctrl: expected FSM events are queued as buttons are driven and
// matched by a monitor as the DUT emits them; a second DUT has STOP_ON_WRAP=0.
module tb_sw_ctrl;

  localparam int DEB  = 20;
  localparam int TDIV = 10;

  localparam int EV_STATE = 16;
  localparam int EV_LAP   = 32;
  localparam int EV_CLR   = 48;

  typedef struct {
    string tag;
    int    code;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] psw = 4'b0000;
  logic       wrap_in = 1'b0;

  logic       tick_en, cnt_clr, lap_latch, disp_lap;
  logic [1:0] state;
  logic [7:0] led;
  logic       tick_en0, cnt_clr0, lap_latch0, disp_lap0;
  logic [1:0] state0;
  logic [7:0] led0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   run_cnt = 0;
  logic [1:0] prev_state = 2'b00;
  exp_t sb_q[$];

  sw_ctrl #(.DEBOUNCE_CYC(DEB), .TICK_DIV(TDIV), .STOP_ON_WRAP(1)) dut (
    .CLK(clk), .RSTn(rst_n), .PSW(psw), .wrap_in(wrap_in),
    .tick_en(tick_en), .cnt_clr(cnt_clr), .lap_latch(lap_latch),
    .disp_lap(disp_lap), .state(state), .LED(led)
  );

  sw_ctrl #(.DEBOUNCE_CYC(DEB), .TICK_DIV(TDIV), .STOP_ON_WRAP(0)) dut0 (
    .CLK(clk), .RSTn(rst_n), .PSW(psw), .wrap_in(wrap_in),
    .tick_en(tick_en0), .cnt_clr(cnt_clr0), .lap_latch(lap_latch0),
    .disp_lap(disp_lap0), .state(state0), .LED(led0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, obs, obs, exp, exp, cyc);
    end
  endtask

  task automatic push_exp(input string tag, input int code);
    exp_t e;
    e.tag  = tag;
    e.code = code;
    sb_q.push_back(e);
  endtask

  task automatic sb_event(input int code);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("unexpected_event", code, 0);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, code, e.code);
      $display("event %s code 0x%0h at cycle %0d", e.tag, code, cyc);
    end
  endtask

  // Monitor: pulses first, then state change, so same-cycle events pop in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_state = 2'b00;
      run_cnt    = 0;
    end else begin
      if (cnt_clr) sb_event(EV_CLR);
      if (lap_latch) sb_event(EV_LAP);
      if (state != prev_state) sb_event(EV_STATE + int'(state));
      prev_state = state;
      if (state == 2'b00) run_cnt = 0;
      else if (state == 2'b01 || state == 2'b11) run_cnt++;
      if (tick_en) begin
        check_eq("tick_phase", run_cnt, TDIV);
        run_cnt = 0;
      end
    end
  end

  task automatic press_btn(input logic [3:0] mask, input int hold);
    psw = mask;
    repeat (hold) @(negedge clk);
    psw = 4'b0000;
    repeat (DEB + 6) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    bit   seen;

    repeat (3) @(negedge clk);
    check_eq("rst_state", state, 0);
    check_eq("rst_led", led, 0);
    check_eq("rst_pulses", {tick_en, cnt_clr, lap_latch, disp_lap}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Start held: state change 23 edges after the first sampling edge.
    push_exp("start_to_run", EV_STATE + 1);
    c0   = cyc;
    psw  = 4'b1000;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (state == 2'b01) seen = 1'b1;
    end
    check_eq("start_latency", cyc - c0 - 1, DEB + 3);
    check_eq("run_led", led, 8'h01);
    repeat (6) @(negedge clk);
    psw = 4'b0000;
    repeat (DEB + 6) @(negedge clk);

    // Stop glitch shorter than the debounce window is ignored.
    press_btn(4'b0100, 15);
    check_eq("stop_glitch", state, 2'b01);

    push_exp("stop_to_stop", EV_STATE + 2);
    press_btn(4'b0100, 25);
    check_eq("stop_state", state, 2'b10);
    check_eq("stop_led", led, 8'h04);
    repeat (30) @(negedge clk);

    push_exp("resume_to_run", EV_STATE + 1);
    press_btn(4'b1000, 25);
    check_eq("resume_state", state, 2'b01);

    push_exp("lap_latch", EV_LAP);
    push_exp("lap_to_lap", EV_STATE + 3);
    press_btn(4'b0001, 25);
    check_eq("lap_disp", disp_lap, 1);
    check_eq("lap_led", led, 8'h03);
    repeat (20) @(negedge clk);

    push_exp("lap_to_run", EV_STATE + 1);
    press_btn(4'b0001, 25);
    check_eq("unlap_disp", disp_lap, 0);
    check_eq("unlap_led", led, 8'h01);

    // Stop and lap together in RUN: stop wins, no lap strobe.
    push_exp("stoplap_to_stop", EV_STATE + 2);
    press_btn(4'b0101, 25);
    check_eq("stoplap_state", state, 2'b10);

    push_exp("clr_pulse", EV_CLR);
    push_exp("clr_to_idle", EV_STATE + 0);
    press_btn(4'b0010, 25);
    check_eq("clr_state", state, 2'b00);
    check_eq("clr_led", led, 8'h00);

    push_exp("idle_clr_pulse", EV_CLR);
    press_btn(4'b0010, 25);
    check_eq("idle_clr_state", state, 2'b00);

    push_exp("restart_to_run", EV_STATE + 1);
    press_btn(4'b1000, 25);
    press_btn(4'b0010, 25);
    check_eq("run_clr_ignored", state, 2'b01);
    check_eq("run_clr_led", led, 8'h01);

    // Wrap asserted during a tick cycle.
    seen = 1'b0;
    for (int i = 0; i < 2 * TDIV + 2 && !seen; i++) begin
      @(negedge clk);
      if (tick_en) seen = 1'b1;
    end
    check_eq("wrap_tick_seen", seen, 1);
    push_exp("wrap_to_stop", EV_STATE + 2);
    wrap_in = 1'b1;
    @(negedge clk);
    wrap_in = 1'b0;
    check_eq("wrap_state", state, 2'b10);
    check_eq("wrap_led", led, 8'h0C);
    check_eq("nowrap_state", state0, 2'b01);
    check_eq("nowrap_led", led0, 8'h09);
    repeat (5) @(negedge clk);

    // Reset dropped asynchronously in the middle of a debounce window.
    psw = 4'b1000;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_state", state, 0);
    check_eq("arst_led", led, 0);
    check_eq("arst_outs", {tick_en, cnt_clr, lap_latch, disp_lap}, 0);
    check_eq("arst_state0", state0, 0);
    check_eq("arst_led0", led0, 0);
    repeat (4) @(negedge clk);
    check_eq("arst_hold", {tick_en, cnt_clr, lap_latch, led0}, 0);
    psw   = 4'b0000;
    rst_n = 1'b1;
    repeat (DEB + 10) @(negedge clk);
    check_eq("post_rst_state", state, 0);
    check_eq("post_rst_led", led, 0);

    check_eq("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
